// File: rtl/cvxif_result_buffer.sv
// Purpose : result FIFO between the example coprocessor and the CV-X-IF result channel.
// Latency : 1 cycle from in_valid_i to out_valid_o. There is no bypass path.
// Backpr. : out_ready_i low holds the head entry. stall_o asks the coprocessor to stop
//           issuing early enough that results already in flight still fit.
// Ports   : clk_i/rst_ni clock and async active-low reset.
//           in_*     push side, which has no ready.
//           out_*    valid/ready result channel toward the CPU.
//           flush_i  discards all entries.
//           stall_o  issue throttle.
//           count_o  occupancy.
//           overflow_o sticky flag that is set when a push is dropped.
module cvxif_result_buffer #(
  parameter int unsigned Depth        = 4,
  parameter int unsigned DataWidth    = 64,
  parameter int unsigned IdWidth      = 4,
  parameter int unsigned SlackEntries = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     in_valid_i,
  input  logic [IdWidth-1:0]       in_id_i,
  input  logic [DataWidth-1:0]     in_data_i,
  input  logic                     in_we_i,
  output logic                     out_valid_o,
  output logic [IdWidth-1:0]       out_id_o,
  output logic [DataWidth-1:0]     out_data_o,
  output logic                     out_we_o,
  input  logic                     out_ready_i,
  input  logic                     flush_i,
  output logic                     stall_o,
  output logic [$clog2(Depth):0]   count_o,
  output logic                     overflow_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthC  = CntW'(Depth);
  localparam logic [CntW-1:0] StallTh = CntW'(Depth - SlackEntries);

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [DataWidth-1:0] data;
    logic                 we;
  } entry_t;

  entry_t          r_mem [Depth];
  logic [PtrW-1:0] r_rd_ptr;
  logic [PtrW-1:0] r_wr_ptr;
  logic [CntW-1:0] r_count;
  logic            r_stall;
  logic            r_overflow;

  logic            w_full;
  logic            w_empty;
  logic            w_pop;
  logic            w_push;
  logic            w_drop;
  logic [CntW-1:0] w_count_next;
  entry_t          w_head;

  assign w_full  = (r_count == DepthC);
  assign w_empty = (r_count == '0);

  // A flush cycle suppresses both the push and the pop. It therefore never
  // flags an overflow.
  assign w_pop  = ~w_empty & out_ready_i & ~flush_i;
  // When the buffer is full, a same-cycle pop frees the slot that is written.
  assign w_push = in_valid_i & ~flush_i & (~w_full | w_pop);
  assign w_drop = in_valid_i & ~flush_i & w_full & ~w_pop;

  always_comb begin
    w_count_next = r_count;
    if (flush_i) begin
      w_count_next = '0;
    end else begin
      w_count_next = r_count + CntW'(w_push) - CntW'(w_pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_stall    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_count <= w_count_next;
      // stall_o reflects the occupancy after this cycle's push and pop.
      r_stall <= (w_count_next >= StallTh) & ~flush_i;
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      if (flush_i) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + PtrW'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PtrW'(1);
        end
      end
    end
  end

  // Storage is not reset. Entries are only ever read while they are covered
  // by r_count.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= '{id: in_id_i, data: in_data_i, we: in_we_i};
    end
  end

  assign w_head = r_mem[r_rd_ptr];

  // The output fields are zeroed while the buffer is empty. Stale storage
  // never reaches the CPU.
  assign out_valid_o = ~w_empty;
  assign out_id_o    = w_empty ? '0   : w_head.id;
  assign out_data_o  = w_empty ? '0   : w_head.data;
  assign out_we_o    = w_empty ? 1'b0 : w_head.we;
  assign stall_o     = r_stall;
  assign count_o     = r_count;
  assign overflow_o  = r_overflow;

endmodule

// File: tb/tb_cvxif_result_buffer.sv
// Purpose : directed bench for cvxif_result_buffer with Depth=4 and SlackEntries=2.
// Latency : inputs are driven and outputs sampled 1ns after each rising edge.
// Backpr. : out_ready_i is driven from the directed sequences.
module tb_cvxif_result_buffer;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        in_valid_i;
  logic [3:0]  in_id_i;
  logic [63:0] in_data_i;
  logic        in_we_i;
  logic        out_valid_o;
  logic [3:0]  out_id_o;
  logic [63:0] out_data_o;
  logic        out_we_o;
  logic        out_ready_i;
  logic        flush_i;
  logic        stall_o;
  logic [2:0]  count_o;
  logic        overflow_o;

  int n_vec = 0;
  int n_err = 0;

  cvxif_result_buffer #(
    .Depth(4), .DataWidth(64), .IdWidth(4), .SlackEntries(2)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .in_valid_i(in_valid_i), .in_id_i(in_id_i), .in_data_i(in_data_i), .in_we_i(in_we_i),
    .out_valid_o(out_valid_o), .out_id_o(out_id_o), .out_data_o(out_data_o), .out_we_o(out_we_o),
    .out_ready_i(out_ready_i), .flush_i(flush_i), .stall_o(stall_o),
    .count_o(count_o), .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  // Present one result for a single clock edge.
  task automatic push(input logic [3:0] id, input logic [63:0] d, input logic we);
    in_valid_i = 1'b1;
    in_id_i    = id;
    in_data_i  = d;
    in_we_i    = we;
    cyc();
    in_valid_i = 1'b0;
  endtask

  // Fill an empty buffer with ids 0..3 while the CPU stalls.
  task automatic fill4(input string tag);
    out_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push(4'(i), 64'(100 + i), i[0]);
      chk({tag, "_cnt"}, 64'(count_o), 64'(i + 1));
      chk({tag, "_stall"}, 64'(stall_o), (i >= 1) ? 64'd1 : 64'd0);
      chk({tag, "_head"}, 64'(out_id_o), 64'd0);
    end
  endtask

  initial begin
    rst_ni      = 1'b0;
    in_valid_i  = 1'b0;
    in_id_i     = '0;
    in_data_i   = '0;
    in_we_i     = 1'b0;
    out_ready_i = 1'b0;
    flush_i     = 1'b0;
    #12;
    chk("rst_valid", 64'(out_valid_o), 64'd0);
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_stall", 64'(stall_o), 64'd0);
    chk("rst_ovf", 64'(overflow_o), 64'd0);
    chk("rst_id", 64'(out_id_o), 64'd0);
    chk("rst_data", out_data_o, 64'd0);
    chk("rst_we", 64'(out_we_o), 64'd0);
    #5 rst_ni = 1'b1;
    cyc();

    // A single result appears one cycle after it is pushed. It leaves on the next edge.
    out_ready_i = 1'b1;
    push(4'd3, 64'hDEAD, 1'b1);
    chk("single_valid", 64'(out_valid_o), 64'd1);
    chk("single_id", 64'(out_id_o), 64'd3);
    chk("single_data", out_data_o, 64'hDEAD);
    chk("single_we", 64'(out_we_o), 64'd1);
    chk("single_cnt", 64'(count_o), 64'd1);
    cyc();
    chk("single_cnt0", 64'(count_o), 64'd0);
    chk("single_vld0", 64'(out_valid_o), 64'd0);
    chk("single_zero", out_data_o, 64'd0);

    // Full buffer with a push and a pop in the same cycle.
    fill4("fillA");
    out_ready_i = 1'b1;
    push(4'd7, 64'h77, 1'b1);
    chk("fullpp_cnt", 64'(count_o), 64'd4);
    chk("fullpp_ovf", 64'(overflow_o), 64'd0);
    chk("fullpp_head", 64'(out_id_o), 64'd1);
    chk("fullpp_stall", 64'(stall_o), 64'd1);
    begin
      logic [3:0] exp_ids [4] = '{4'd1, 4'd2, 4'd3, 4'd7};
      for (int i = 0; i < 4; i++) begin
        chk("fullpp_order", 64'(out_id_o), 64'(exp_ids[i]));
        cyc();
      end
    end
    chk("fullpp_empty", 64'(out_valid_o), 64'd0);
    chk("fullpp_stall0", 64'(stall_o), 64'd0);

    // A push into a full buffer with no pop is dropped, and overflow_o stays set.
    fill4("fillB");
    push(4'd5, 64'h55, 1'b0);
    chk("ovf_flag", 64'(overflow_o), 64'd1);
    chk("ovf_cnt", 64'(count_o), 64'd4);
    chk("ovf_head", 64'(out_id_o), 64'd0);
    chk("ovf_hold_data", out_data_o, 64'd100);
    out_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("ovf_order", 64'(out_id_o), 64'(i));
      chk("ovf_data", out_data_o, 64'(100 + i));
      chk("ovf_we", 64'(out_we_o), 64'(i % 2));
      cyc();
    end
    chk("ovf_no5", 64'(out_valid_o), 64'd0);
    chk("ovf_sticky", 64'(overflow_o), 64'd1);

    // A flush discards the contents and the push made in the same cycle.
    out_ready_i = 1'b0;
    push(4'hA, 64'hA0, 1'b1);
    push(4'hB, 64'hB0, 1'b1);
    push(4'hC, 64'hC0, 1'b1);
    chk("fl_pre_cnt", 64'(count_o), 64'd3);
    chk("fl_pre_stall", 64'(stall_o), 64'd1);
    flush_i = 1'b1;
    push(4'hE, 64'hE0, 1'b1);
    flush_i = 1'b0;
    chk("fl_cnt", 64'(count_o), 64'd0);
    chk("fl_valid", 64'(out_valid_o), 64'd0);
    chk("fl_stall", 64'(stall_o), 64'd0);
    chk("fl_ovf_kept", 64'(overflow_o), 64'd1);
    cyc();
    chk("fl_noE", 64'(out_valid_o), 64'd0);
    push(4'h6, 64'h66, 1'b0);
    chk("fl_after_id", 64'(out_id_o), 64'd6);
    push(4'h9, 64'h99, 1'b1);
    chk("fl_after_cnt", 64'(count_o), 64'd2);
    chk("fl_after_stall", 64'(stall_o), 64'd1);

    // An asynchronous reset between edges clears the outputs at once.
    #3 rst_ni = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid_o), 64'd0);
    chk("arst_stall", 64'(stall_o), 64'd0);
    chk("arst_cnt", 64'(count_o), 64'd0);
    chk("arst_ovf", 64'(overflow_o), 64'd0);
    chk("arst_id", 64'(out_id_o), 64'd0);
    #10 rst_ni = 1'b1;
    cyc();
    chk("arst_post", 64'(out_valid_o), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
